// File: rtl/palette_pkg.sv
// palette_pkg: shared colour type, FSM states and the default palette tables.
package palette_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [11:0] TAB_A [8] = '{12'h320, 12'hA75, 12'h888, 12'hCB9,
                                        12'h631, 12'h111, 12'h443, 12'hFFF};
  localparam logic [11:0] TAB_B [8] = '{12'hF00, 12'hA7F, 12'hFF0, 12'h02F,
                                        12'h472, 12'h346, 12'h732, 12'hFFF};

  // Palette 1 boots with table B, every other palette with table A; entries past 7 are black.
  function automatic rgb_t def_entry(input int pal, input int idx);
    return rgb_t'((idx >= 8) ? 12'h000 : (pal == 1) ? TAB_B[idx[2:0]] : TAB_A[idx[2:0]]);
  endfunction

endpackage

// File: rtl/palette_lookup_pipe_if.sv
// palette_lookup_pipe_if: pixel, palette-write, index-memory and RGB signals of the palette stage.
interface palette_lookup_pipe_if #(
  parameter int ADDR_W  = 19,
  parameter int INDEX_W = 3,
  parameter int NUM_PAL = 4
);
  localparam int PSEL_W = NUM_PAL > 1 ? $clog2(NUM_PAL) : 1;

  logic [9:0]         drawX;
  logic [9:0]         drawY;
  logic               pix_valid;
  logic               frame_start;
  logic [PSEL_W-1:0]  pal_sel;
  logic               pal_we;
  logic [PSEL_W-1:0]  pal_wsel;
  logic [INDEX_W-1:0] pal_widx;
  logic [11:0]        pal_wdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INDEX_W-1:0] mem_q;
  logic [3:0]         red;
  logic [3:0]         green;
  logic [3:0]         blue;
  logic               pix_valid_out;
  logic               pix_transparent;
  logic               init_busy;

  modport master (
    output drawX, drawY, pix_valid, frame_start, pal_sel, pal_we, pal_wsel, pal_widx, pal_wdata, mem_q,
    input  mem_addr, red, green, blue, pix_valid_out, pix_transparent, init_busy
  );

  modport slave (
    input  drawX, drawY, pix_valid, frame_start, pal_sel, pal_we, pal_wsel, pal_widx, pal_wdata, mem_q,
    output mem_addr, red, green, blue, pix_valid_out, pix_transparent, init_busy
  );

endinterface

// File: rtl/palette_ram.sv
// palette_ram: palette storage, one sync write port and one registered read-before-write port.
module palette_ram
  import palette_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  rgb_t          wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output rgb_t          rdata_o
);

  rgb_t ram_q [DEPTH];
  rgb_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) ram_q[waddr_i] <= wdata_i;
  end

  // A disabled read returns black so the output register doubles as the blanking stage.
  always_ff @(posedge clk) begin
    rdata_q <= (rst || !re_i) ? '0 : ram_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/palette_lookup_pipe.sv
// palette_lookup_pipe: coordinate -> index memory -> frame-synchronous palette -> RGB.
// Optional PALETTE_TRANSPARENT_EN flags valid pixels whose colour index is 0.
module palette_lookup_pipe
  import palette_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int INDEX_W = 3,
  parameter int NUM_PAL = 4,
  parameter int MEM_LAT = 1
) (
  input logic Clk,
  input logic Reset,
  palette_lookup_pipe_if.slave bus
);

  localparam int PSEL_W = NUM_PAL > 1 ? $clog2(NUM_PAL) : 1;
  localparam int DEPTH  = NUM_PAL << INDEX_W;
  localparam int AW     = $clog2(DEPTH);

  state_e                     state_q;
  logic [AW-1:0]              cnt_q;
  logic                       busy_q;
  logic [PSEL_W-1:0]          act_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [MEM_LAT:0]           v_q;
  logic [MEM_LAT:0][PSEL_W-1:0] p_q;
  logic                       vo_q;
  logic                       run;
  logic                       in_ok;
  logic                       ram_we;
  logic [AW-1:0]              ram_waddr;
  logic [AW-1:0]              ram_raddr;
  rgb_t                       ram_wdata;
  rgb_t                       rgb_q;

  assign run   = state_q == RUN;
  assign in_ok = run && bus.pix_valid && 32'(bus.drawX) < 32'(H_RES) && 32'(bus.drawY) < 32'(V_RES);

  // INIT owns the write port; in RUN it belongs to the external palette writer.
  always_comb begin
    ram_we    = run ? bus.pal_we && 32'(bus.pal_wsel) < 32'(NUM_PAL) : 1'b1;
    ram_waddr = run ? AW'({bus.pal_wsel, bus.pal_widx}) : cnt_q;
    ram_wdata = run ? rgb_t'(bus.pal_wdata) : def_entry(int'(cnt_q >> INDEX_W), int'(cnt_q[INDEX_W-1:0]));
    ram_raddr = AW'({p_q[MEM_LAT], bus.mem_q});
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      act_q   <= '0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end
    end else if (bus.frame_start && 32'(bus.pal_sel) < 32'(NUM_PAL)) begin
      act_q <= bus.pal_sel;
    end
  end

  // Valid and palette travel alongside the address so they meet mem_q at the lookup.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q <= '0;
      v_q    <= '0;
      p_q    <= '0;
      vo_q   <= 1'b0;
    end else begin
      if (in_ok) addr_q <= ADDR_W'(32'(bus.drawX) + 32'(H_RES) * 32'(bus.drawY));
      v_q  <= {v_q[MEM_LAT-1:0], in_ok};
      p_q  <= {p_q[MEM_LAT-1:0], act_q};
      vo_q <= v_q[MEM_LAT];
    end
  end

  palette_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (Clk),
    .rst     (Reset),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (v_q[MEM_LAT]),
    .raddr_i (ram_raddr),
    .rdata_o (rgb_q)
  );

`ifdef PALETTE_TRANSPARENT_EN
  logic tr_q;
  always_ff @(posedge Clk) begin
    tr_q <= !Reset && v_q[MEM_LAT] && bus.mem_q == '0;
  end
  assign bus.pix_transparent = tr_q;
`else
  assign bus.pix_transparent = 1'b0;
`endif

  assign bus.mem_addr      = addr_q;
  assign bus.red           = rgb_q.r;
  assign bus.green         = rgb_q.g;
  assign bus.blue          = rgb_q.b;
  assign bus.pix_valid_out = vo_q;
  assign bus.init_busy     = busy_q;

endmodule

// File: tb/tb_palette_lookup_pipe.sv
// tb_palette_lookup_pipe: directed and random stimulus against a palette/latency reference model.
module tb_palette_lookup_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  palette_lookup_pipe_if bus ();
  palette_lookup_pipe dut (.Clk(clk), .Reset(rst), .bus(bus));

  always #5 clk = ~clk;

  bit [2:0] tbmem [int];

  function automatic bit [2:0] mem_at(input int a);
    return tbmem.exists(a) ? tbmem[a] : 3'((a * 5 + a / 7) & 7);
  endfunction

  always @(posedge clk) bus.mem_q <= mem_at(int'(bus.mem_addr));

  typedef struct {
    bit v;
    int pal;
    int idx;
  } pix_t;

  logic [11:0] tab_a [8] = '{12'h320, 12'hA75, 12'h888, 12'hCB9, 12'h631, 12'h111, 12'h443, 12'hFFF};
  logic [11:0] tab_b [8] = '{12'hF00, 12'hA7F, 12'hFF0, 12'h02F, 12'h472, 12'h346, 12'h732, 12'hFFF};
  logic [11:0] pal_m [4][8];
  pix_t pipe [3];
  int m_init = 0;
  int act = 0;
  int m_addr = 0;
  int e_rgb = 0;
  int e_pvo = 0;
  int e_tr = 0;

  task automatic model();
    pix_t np;
    if (rst) begin
      m_init = 32;
      act = 0;
      m_addr = 0;
      for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, pal: 0, idx: 0};
      for (int p = 0; p < 4; p++)
        for (int i = 0; i < 8; i++) pal_m[p][i] = (p == 1) ? tab_b[i] : tab_a[i];
      e_rgb = 0;
      e_pvo = 0;
      e_tr = 0;
      return;
    end
    np = '{v: 1'b0, pal: act, idx: 0};
    if (m_init == 0 && bus.pix_valid && bus.drawX < 640 && bus.drawY < 480) begin
      np.v = 1'b1;
      m_addr = int'(bus.drawX) + 640 * int'(bus.drawY);
      np.idx = int'(mem_at(m_addr));
    end
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = np;
    e_pvo = int'(pipe[2].v);
    e_rgb = pipe[2].v ? int'(pal_m[pipe[2].pal][pipe[2].idx]) : 0;
`ifdef PALETTE_TRANSPARENT_EN
    e_tr = int'(pipe[2].v && pipe[2].idx == 0);
`else
    e_tr = 0;
`endif
    if (m_init == 0) begin
      if (bus.pal_we) pal_m[int'(bus.pal_wsel)][int'(bus.pal_widx)] = bus.pal_wdata;
      if (bus.frame_start) act = int'(bus.pal_sel);
    end else begin
      m_init--;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rgb();
    return int'({bus.red, bus.green, bus.blue});
  endfunction

  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("rgb", rgb(), e_rgb);
    chk("pix_valid_out", int'(bus.pix_valid_out), e_pvo);
    chk("init_busy", int'(bus.init_busy), int'(m_init > 0));
    chk("mem_addr", int'(bus.mem_addr), m_addr);
    chk("pix_transparent", int'(bus.pix_transparent), e_tr);
  endtask

  task automatic px(input int x, input int y, input bit v);
    bus.drawX = 10'(x);
    bus.drawY = 10'(y);
    bus.pix_valid = v;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (bus.init_busy && n < 100) begin
      step();
      n++;
    end
    chk(tag, n, 32);
  endtask

  initial begin
    px(0, 0, 1'b0);
    bus.frame_start = 1'b0;
    bus.pal_sel = '0;
    bus.pal_we = 1'b0;
    bus.pal_wsel = '0;
    bus.pal_widx = '0;
    bus.pal_wdata = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wait_init("init_len");

    tbmem[1] = 3'd1;
    px(1, 0, 1'b1); step(); px(0, 0, 1'b0); step(); step();
    chk("p0_idx1", rgb(), 'hA75);

    bus.pal_sel = 2'd1; bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;
    tbmem[2] = 3'd0;
    px(2, 0, 1'b1); step(); px(0, 0, 1'b0); step(); step();
    chk("p1_idx0", rgb(), 'hF00);
    bus.pal_sel = 2'd0; bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;

    tbmem[1285] = 3'd3;
    px(5, 2, 1'b1); step();
    chk("addr_1285", int'(bus.mem_addr), 1285);
    px(0, 0, 1'b0); step(); step();
    chk("idx3_rgb", rgb(), 'hCB9);

    bus.pal_sel = 2'd1;
    tbmem[1286] = 3'd3;
    px(6, 2, 1'b1); step(); px(0, 0, 1'b0); step(); step();
    chk("sel_no_fs", rgb(), 'hCB9);
    bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;
    tbmem[1287] = 3'd7;
    tbmem[1288] = 3'd2;
    px(7, 2, 1'b1); step(); px(8, 2, 1'b1); step(); px(0, 0, 1'b0); step();
    chk("fs_idx7", rgb(), 'hFFF);
    step();
    chk("fs_idx2", rgb(), 'hFF0);
    bus.pal_sel = 2'd0; bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;

    for (int i = 0; i < 8; i++) tbmem[10 + i] = 3'd4;
    bus.pal_wsel = 2'd0; bus.pal_widx = 3'd4; bus.pal_wdata = 12'h0F0;
    for (int i = 0; i < 8; i++) begin
      px(10 + i, 0, 1'b1);
      bus.pal_we = (i == 4);
      step();
      if (i == 4) chk("wr_same_cycle", rgb(), 'h631);
      if (i == 5) chk("wr_next_cycle", rgb(), 'h0F0);
    end
    bus.pal_we = 1'b0;
    px(0, 0, 1'b0); step(); step(); step();

    px(3, 0, 1'b1); step();
    px(640, 0, 1'b1); step();
    chk("oob_addr_hold", int'(bus.mem_addr), 3);
    px(4, 0, 1'b1); step();
    px(0, 0, 1'b0); step();
    chk("oob_rgb", rgb(), 0);
    chk("oob_pvo", int'(bus.pix_valid_out), 0);
    step();
    chk("after_oob_pvo", int'(bus.pix_valid_out), 1);

    px(20, 1, 1'b1); step(); px(21, 1, 1'b1); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_rgb", rgb(), 0);
    chk("rst_pvo", int'(bus.pix_valid_out), 0);
    chk("rst_busy", int'(bus.init_busy), 1);
    px(0, 0, 1'b0);
    wait_init("reinit_len");

    for (int i = 0; i < 400; i++) begin
      px($urandom_range(0, 660), $urandom_range(0, 490), $urandom_range(0, 3) != 0);
      bus.frame_start = $urandom_range(0, 15) == 0;
      bus.pal_sel = 2'($urandom);
      bus.pal_we = $urandom_range(0, 7) == 0;
      bus.pal_wsel = 2'($urandom);
      bus.pal_widx = 3'($urandom);
      bus.pal_wdata = 12'($urandom);
      rst = (i == 200);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
